instr_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It captures each fetched instruction with its PC and buffers up to DEPTH entries. It presents them in order to decode using a valid/ready handshake. A flush discards all buffered entries when the PC is redirected by a branch or jump.

---
 rtl/instr_queue.sv | 102 ++++++++++
 tb/tb_instr_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of {pc, instr} entries, presented in order through a valid/ready handshake.
// A flush drops every buffered entry and any push offered in the same cycle.
module instr_queue #(
    parameter int unsigned          DEPTH     = 2,
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      NOP_INSTR = 'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    fetch_valid_i,
    input  logic [XLEN-1:0]         fetch_pc_i,
    input  logic [XLEN-1:0]         fetch_instr_i,
    output logic                    fetch_ready_o,
    output logic                    dec_valid_o,
    output logic [XLEN-1:0]         dec_pc_o,
    output logic [XLEN-1:0]         dec_instr_o,
    input  logic                    dec_ready_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic push;
    logic pop;

    // Handshake outputs; fetch_ready depends only on occupancy, never on dec_ready_i.
    always_comb begin
        fetch_ready_o = !reset && (count_q < CntW'(DEPTH));
        dec_valid_o   = (count_q != '0);
        dec_pc_o      = '0;
        dec_instr_o   = NOP_INSTR;
        if (dec_valid_o) begin
            dec_pc_o    = pc_mem[rd_ptr_q];
            dec_instr_o = instr_mem[rd_ptr_q];
        end
        count_o = count_q;
    end

    // Push/pop qualification and next pointer/count state; flush wins over both.
    always_comb begin
        push     = fetch_valid_i && fetch_ready_o && !flush_i;
        pop      = dec_valid_o && dec_ready_i && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // Discard everything: read pointer catches up with write pointer.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are never cleared, validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_i;
            instr_mem[wr_ptr_q] <= fetch_instr_i;
        end
    end

    // Occupancy must stay within the buffer.
    assert property (@(posedge clk) disable iff (reset) (count_q <= CntW'(DEPTH)));

    // A recorded push always had a free slot.
    assert property (@(posedge clk) disable iff (reset) (push |-> fetch_ready_o));

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=2, XLEN=32).
module tb_instr_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk;
    logic            reset;
    logic            flush_i;
    logic            fetch_valid_i;
    logic [XLEN-1:0] fetch_pc_i;
    logic [XLEN-1:0] fetch_instr_i;
    logic            fetch_ready_o;
    logic            dec_valid_o;
    logic [XLEN-1:0] dec_pc_o;
    logic [XLEN-1:0] dec_instr_o;
    logic            dec_ready_i;
    logic [1:0]      count_o;

    int checks = 0;
    int errors = 0;

    instr_queue #(
        .DEPTH     (DEPTH),
        .XLEN      (XLEN),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .fetch_ready_o (fetch_ready_o),
        .dec_valid_o   (dec_valid_o),
        .dec_pc_o      (dec_pc_o),
        .dec_instr_o   (dec_instr_o),
        .dec_ready_i   (dec_ready_i),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch_ready: got %b expected 0", fetch_ready_o);
        end
        checks++;
        if (dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_dec_valid: got %b expected 0", dec_valid_o);
        end
        checks++;
        if (dec_instr_o !== NOP || dec_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_dec_out: got pc=%h instr=%h expected pc=0 instr=%h",
                     dec_pc_o, dec_instr_o, NOP);
        end
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count_o);
        end
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL release_fetch_ready: got %b expected 1", fetch_ready_o);
        end
    endtask

    task automatic test_single_push();
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h0;
        fetch_instr_i = 32'h0050_0093;
        dec_ready_i   = 1'b0;
        #1;
        checks++;
        if (dec_instr_o !== NOP || count_o !== 2'd0) begin
            errors++;
            $display("FAIL pre_push_empty: got instr=%h count=%0d expected instr=%h count=0",
                     dec_instr_o, count_o, NOP);
        end
        cycle();
        fetch_valid_i = 1'b0;
        checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0 || dec_instr_o !== 32'h0050_0093 ||
            count_o !== 2'd1) begin
            errors++;
            $display("FAIL single_push: got v=%b pc=%h instr=%h count=%0d expected v=1 pc=0 instr=00500093 count=1",
                     dec_valid_o, dec_pc_o, dec_instr_o, count_o);
        end
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: got count=%0d v=%b expected count=0 v=0",
                     count_o, dec_valid_o);
        end
    endtask

    task automatic test_fill();
        dec_ready_i   = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h0;
        fetch_instr_i = 32'hA000_0000;
        cycle();
        fetch_pc_i    = 32'h4;
        fetch_instr_i = 32'hA000_0004;
        cycle();
        checks++;
        if (count_o !== 2'd2 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got count=%0d ready=%b expected count=2 ready=0",
                     count_o, fetch_ready_o);
        end
        fetch_pc_i    = 32'h8;
        fetch_instr_i = 32'hA000_0008;
        cycle();
        fetch_valid_i = 1'b0;
        checks++;
        if (count_o !== 2'd2 || dec_pc_o !== 32'h0 || dec_instr_o !== 32'hA000_0000) begin
            errors++;
            $display("FAIL fill_overflow: got count=%0d pc=%h instr=%h expected count=2 pc=0 instr=a0000000",
                     count_o, dec_pc_o, dec_instr_o);
        end
        dec_ready_i = 1'b1;
        cycle();
        checks++;
        if (count_o !== 2'd1 || dec_pc_o !== 32'h4 || dec_instr_o !== 32'hA000_0004 ||
            fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_first: got count=%0d pc=%h instr=%h ready=%b expected count=1 pc=4 instr=a0000004 ready=1",
                     count_o, dec_pc_o, dec_instr_o, fetch_ready_o);
        end
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0 || dec_instr_o !== NOP) begin
            errors++;
            $display("FAIL drain_empty: got count=%0d v=%b instr=%h expected count=0 v=0 instr=%h",
                     count_o, dec_valid_o, dec_instr_o, NOP);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        dec_ready_i   = 1'b1;
        fetch_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc            = 32'(i * 4);
            fetch_pc_i    = pc;
            fetch_instr_i = 32'hB000_0000 | pc;
            cycle();
            checks++;
            if (dec_valid_o !== 1'b1 || dec_pc_o !== pc || dec_instr_o !== (32'hB000_0000 | pc) ||
                count_o !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h count=%0d expected v=1 pc=%h instr=%h count=1",
                         i, dec_valid_o, dec_pc_o, dec_instr_o, count_o, pc, 32'hB000_0000 | pc);
            end
        end
        fetch_valid_i = 1'b0;
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got count=%0d v=%b expected count=0 v=0",
                     count_o, dec_valid_o);
        end
    endtask

    task automatic test_flush();
        dec_ready_i   = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h10;
        fetch_instr_i = 32'hC000_0010;
        cycle();
        fetch_pc_i    = 32'h14;
        fetch_instr_i = 32'hC000_0014;
        cycle();
        flush_i       = 1'b1;
        fetch_pc_i    = 32'h18;
        fetch_instr_i = 32'hC000_0018;
        dec_ready_i   = 1'b1;
        cycle();
        flush_i       = 1'b0;
        dec_ready_i   = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got count=%0d v=%b expected count=0 v=0",
                     count_o, dec_valid_o);
        end
        fetch_pc_i    = 32'h100;
        fetch_instr_i = 32'hC000_0100;
        cycle();
        checks++;
        if (dec_pc_o !== 32'h100 || dec_instr_o !== 32'hC000_0100 || count_o !== 2'd1) begin
            errors++;
            $display("FAIL flush_redirect: got pc=%h instr=%h count=%0d expected pc=100 instr=c0000100 count=1",
                     dec_pc_o, dec_instr_o, count_o);
        end
        // With a free slot the same-cycle push must still be dropped.
        flush_i       = 1'b1;
        fetch_pc_i    = 32'h104;
        fetch_instr_i = 32'hC000_0104;
        cycle();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_push: got count=%0d v=%b expected count=0 v=0",
                     count_o, dec_valid_o);
        end
    endtask

    task automatic test_async_reset();
        dec_ready_i   = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h30;
        fetch_instr_i = 32'hD000_0030;
        cycle();
        fetch_pc_i    = 32'h34;
        fetch_instr_i = 32'hD000_0034;
        cycle();
        fetch_valid_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 ||
            dec_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d v=%b ready=%b pc=%h expected count=0 v=0 ready=0 pc=0",
                     count_o, dec_valid_o, fetch_ready_o, dec_pc_o);
        end
        cycle();
        reset         = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h200;
        fetch_instr_i = 32'hD000_0200;
        cycle();
        fetch_valid_i = 1'b0;
        checks++;
        if (dec_pc_o !== 32'h200 || dec_instr_o !== 32'hD000_0200 || count_o !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_push: got pc=%h instr=%h count=%0d expected pc=200 instr=d0000200 count=1",
                     dec_pc_o, dec_instr_o, count_o);
        end
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_stale: got count=%0d v=%b expected count=0 v=0",
                     count_o, dec_valid_o);
        end
    endtask

    task automatic test_empty_pop();
        fetch_valid_i = 1'b0;
        dec_ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (count_o !== 2'd0 || dec_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL empty_pop_%0d: got count=%0d v=%b expected count=0 v=0",
                         i, count_o, dec_valid_o);
            end
        end
        dec_ready_i   = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h300;
        fetch_instr_i = 32'hE000_0300;
        cycle();
        fetch_valid_i = 1'b0;
        checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h300 || dec_instr_o !== 32'hE000_0300 ||
            count_o !== 2'd1) begin
            errors++;
            $display("FAIL empty_pop_push: got v=%b pc=%h instr=%h count=%0d expected v=1 pc=300 instr=e0000300 count=1",
                     dec_valid_o, dec_pc_o, dec_instr_o, count_o);
        end
        dec_ready_i = 1'b1;
        cycle();
        dec_ready_i = 1'b0;
        checks++;
        if (count_o !== 2'd0) begin
            errors++;
            $display("FAIL empty_pop_drain: got count=%0d expected 0", count_o);
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = '0;
        fetch_instr_i = '0;
        dec_ready_i   = 1'b0;
        test_reset();
        test_single_push();
        test_fill();
        test_stream();
        test_flush();
        test_async_reset();
        test_empty_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
